// File: rtl/button_pkg.sv
// Shared constants and configuration helpers for the push-button debouncer bank.
package button_pkg;

    localparam int unsigned BUTTON_COUNTER_SIZE  = 32'd8;
    localparam int unsigned BUTTON_COUNTER_VALUE = 32'd255;
    localparam int unsigned BUTTON_COUNT         = 32'd8;

    // True when the terminal count is non-zero and representable in a counter of the given width.
    function automatic bit counter_value_fits(input int unsigned size, input int unsigned value);
        longint unsigned max_value;
        max_value = (64'd1 << size) - 64'd1;
        return (value >= 32'd1) && (64'(value) <= max_value);
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debouncer channel: two-flop synchroniser, stability counter, debounced level,
// press/release pulses and a sticky press flag with a clear strobe.
module debounce_channel
    import button_pkg::*;
#(
    parameter int unsigned COUNTER_SIZE  = BUTTON_COUNTER_SIZE,
    parameter int unsigned COUNTER_VALUE = BUTTON_COUNTER_VALUE
) (
    input  logic clk,
    input  logic reset,
    input  logic button_in,
    input  logic latch_clear,
    output logic state,
    output logic pressed,
    output logic released,
    output logic latched
);

    localparam logic [COUNTER_SIZE-1:0] TERMINAL_COUNT = COUNTER_SIZE'(COUNTER_VALUE);
    localparam logic [COUNTER_SIZE-1:0] COUNT_ONE      = COUNTER_SIZE'(32'd1);
    localparam logic [COUNTER_SIZE-1:0] COUNT_ZERO     = COUNTER_SIZE'(32'd0);

    logic                    sync1_q, sync1_d;
    logic                    sync2_q, sync2_d;
    logic [COUNTER_SIZE-1:0] count_q, count_d;
    logic                    state_q, state_d;
    logic                    pressed_q, pressed_d;
    logic                    released_q, released_d;
    logic                    latched_q, latched_d;
    logic                    mismatch_s;
    logic                    accept_s;

    // Next-state logic: the counter only advances while the synchronised input disagrees
    // with the debounced level, so any single agreeing sample restarts the count.
    always_comb begin
        sync1_d    = button_in;
        sync2_d    = sync1_q;
        count_d    = count_q;
        state_d    = state_q;
        accept_s   = 1'b0;
        mismatch_s = (sync2_q != state_q);

        if (!mismatch_s) begin
            count_d = COUNT_ZERO;
        end else if (count_q == TERMINAL_COUNT) begin
            count_d  = COUNT_ZERO;
            state_d  = sync2_q;
            accept_s = 1'b1;
        end else begin
            count_d = count_q + COUNT_ONE;
        end

        pressed_d  = accept_s & sync2_q;
        released_d = accept_s & ~sync2_q;

        // A press wins over a simultaneous clear so no press is ever lost.
        if (pressed_d) begin
            latched_d = 1'b1;
        end else if (latch_clear) begin
            latched_d = 1'b0;
        end else begin
            latched_d = latched_q;
        end
    end

    // State registers with synchronous reset that discards any partially counted transition.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            count_q    <= COUNT_ZERO;
            state_q    <= 1'b0;
            pressed_q  <= 1'b0;
            released_q <= 1'b0;
            latched_q  <= 1'b0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            count_q    <= count_d;
            state_q    <= state_d;
            pressed_q  <= pressed_d;
            released_q <= released_d;
            latched_q  <= latched_d;
        end
    end

    assign state    = state_q;
    assign pressed  = pressed_q;
    assign released = released_q;
    assign latched  = latched_q;

endmodule

// File: rtl/button_bank.sv
// Bank of independent push-button debouncers with a registered "any flag set" summary.
module button_bank
    import button_pkg::*;
#(
    parameter int unsigned NUM_BUTTONS   = BUTTON_COUNT,
    parameter int unsigned COUNTER_SIZE  = BUTTON_COUNTER_SIZE,
    parameter int unsigned COUNTER_VALUE = BUTTON_COUNTER_VALUE
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_BUTTONS-1:0] buttons_in,
    input  logic [NUM_BUTTONS-1:0] latch_clear,
    output logic [NUM_BUTTONS-1:0] buttons_state,
    output logic [NUM_BUTTONS-1:0] pressed,
    output logic [NUM_BUTTONS-1:0] released,
    output logic [NUM_BUTTONS-1:0] latched,
    output logic                   any_latched
);

    if (!counter_value_fits(COUNTER_SIZE, COUNTER_VALUE)) begin : g_bad_cfg
        $error("button_bank: COUNTER_VALUE must be in 1 .. 2**COUNTER_SIZE-1");
    end

    logic [NUM_BUTTONS-1:0] latched_s;
    logic                   any_latched_q, any_latched_d;

    for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_channel
        debounce_channel #(
            .COUNTER_SIZE  (COUNTER_SIZE),
            .COUNTER_VALUE (COUNTER_VALUE)
        ) u_channel (
            .clk         (clk),
            .reset       (reset),
            .button_in   (buttons_in[i]),
            .latch_clear (latch_clear[i]),
            .state       (buttons_state[i]),
            .pressed     (pressed[i]),
            .released    (released[i]),
            .latched     (latched_s[i])
        );
    end

    // Summary flag input: OR of all sticky flags, sampled one cycle later.
    always_comb begin
        if (|latched_s) begin
            any_latched_d = 1'b1;
        end else begin
            any_latched_d = 1'b0;
        end
    end

    // Summary flag register.
    always_ff @(posedge clk) begin
        if (reset) begin
            any_latched_q <= 1'b0;
        end else begin
            any_latched_q <= any_latched_d;
        end
    end

    assign latched     = latched_s;
    assign any_latched = any_latched_q;

endmodule

// File: tb/tb_button_bank.sv
// Randomised and directed bench for button_bank, checked against a sample-history model.
module tb_button_bank;

    localparam int NB = 4;
    localparam int CS = 3;
    localparam int CV = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [NB-1:0] buttons_in = '0;
    logic [NB-1:0] latch_clear = '0;
    logic [NB-1:0] buttons_state, pressed, released, latched;
    logic          any_latched;

    int n_checks = 0;
    int n_errors = 0;

    // Model: every raw sample taken since reset, and the synchronised sample seen at each edge.
    bit raw_log [NB][$];
    bit s2_log  [NB][$];
    bit m_state [NB];
    bit m_press [NB];
    bit m_rel   [NB];
    bit m_lat   [NB];
    bit m_any;

    button_bank #(
        .NUM_BUTTONS   (NB),
        .COUNTER_SIZE  (CS),
        .COUNTER_VALUE (CV)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .buttons_in    (buttons_in),
        .latch_clear   (latch_clear),
        .buttons_state (buttons_state),
        .pressed       (pressed),
        .released      (released),
        .latched       (latched),
        .any_latched   (any_latched)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            if (n_errors <= 40)
                $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    // A channel flips when the last CV+1 synchronised samples (the raw level two edges
    // earlier) all differ from the debounced level.
    task automatic model_edge();
        bit old_any;
        old_any = 1'b0;
        for (int c = 0; c < NB; c++) old_any |= m_lat[c];
        if (reset) begin
            for (int c = 0; c < NB; c++) begin
                raw_log[c].delete();
                s2_log[c].delete();
                m_state[c] = 1'b0; m_press[c] = 1'b0; m_rel[c] = 1'b0; m_lat[c] = 1'b0;
            end
            m_any = 1'b0;
        end else begin
            for (int c = 0; c < NB; c++) begin
                bit s2;
                bit flip;
                s2 = (raw_log[c].size() >= 2) ? raw_log[c][raw_log[c].size()-2] : 1'b0;
                s2_log[c].push_back(s2);
                flip = (s2_log[c].size() >= CV + 1);
                if (flip)
                    for (int k = 1; k <= CV + 1; k++)
                        if (s2_log[c][s2_log[c].size()-k] == m_state[c]) flip = 1'b0;
                m_press[c] = flip && !m_state[c];
                m_rel[c]   = flip && m_state[c];
                if (flip) begin
                    m_state[c] = ~m_state[c];
                    s2_log[c].delete();
                end
                if (m_press[c])          m_lat[c] = 1'b1;
                else if (latch_clear[c]) m_lat[c] = 1'b0;
                raw_log[c].push_back(buttons_in[c]);
                if (raw_log[c].size() > 8) void'(raw_log[c].pop_front());
                if (s2_log[c].size() > 16) void'(s2_log[c].pop_front());
            end
            m_any = old_any;
        end
    endtask

    task automatic check_all();
        logic [NB-1:0] es, ep, er, el;
        for (int c = 0; c < NB; c++) begin
            es[c] = m_state[c]; ep[c] = m_press[c]; er[c] = m_rel[c]; el[c] = m_lat[c];
        end
        check_eq("buttons_state", 32'(buttons_state), 32'(es));
        check_eq("pressed",       32'(pressed),       32'(ep));
        check_eq("released",      32'(released),      32'(er));
        check_eq("latched",       32'(latched),       32'(el));
        check_eq("any_latched",   32'(any_latched),   32'(m_any));
        check_eq("press_rel_excl", 32'(pressed & released), 32'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    int hold [NB];
    int press_edge2, rel_edge3;

    initial begin
        // Reset, then test 1: channel 0 held high from edge 0.
        reset = 1'b1;
        ticks(2);
        reset = 1'b0;
        buttons_in = 4'b0001;
        for (int e = 0; e <= 7; e++) begin
            tick();
            check_eq("t1_state0",   32'(buttons_state[0]), (e >= 6) ? 32'd1 : 32'd0);
            check_eq("t1_pressed0", 32'(pressed[0]),       (e == 6) ? 32'd1 : 32'd0);
            check_eq("t1_latched0", 32'(latched[0]),       (e >= 6) ? 32'd1 : 32'd0);
            check_eq("t1_any",      32'(any_latched),      (e >= 7) ? 32'd1 : 32'd0);
        end

        // Test 2: bounce on channel 1, then stable high.
        for (int k = 0; k < 5; k++) begin
            buttons_in[1] = ~k[0];
            tick();
        end
        buttons_in[1] = 1'b1;
        ticks(10);
        check_eq("t2_state1", 32'(buttons_state[1]), 32'd1);

        // Test 3: release channel 0; latched stays set.
        buttons_in[0] = 1'b0;
        ticks(10);
        check_eq("t3_state0",   32'(buttons_state[0]), 32'd0);
        check_eq("t3_latched0", 32'(latched[0]),       32'd1);

        // Test 4: clear, then clear coinciding with a new press.
        latch_clear[0] = 1'b1;
        tick();
        latch_clear[0] = 1'b0;
        check_eq("t4_cleared", 32'(latched[0]), 32'd0);
        buttons_in[0] = 1'b1;
        ticks(6);
        latch_clear[0] = 1'b1;
        tick();
        latch_clear[0] = 1'b0;
        check_eq("t4_set_wins_p", 32'(pressed[0]), 32'd1);
        check_eq("t4_set_wins_l", 32'(latched[0]), 32'd1);

        // Test 5: reset while channel 2 is mid-count.
        buttons_in[2] = 1'b1;
        ticks(5);
        reset = 1'b1;
        tick();
        check_eq("t5_reset_state", 32'(buttons_state), 32'd0);
        check_eq("t5_reset_lat",   32'(latched),       32'd0);
        reset = 1'b0;
        for (int e = 0; e <= 6; e++) begin
            tick();
            check_eq("t5_state2", 32'(buttons_state[2]), (e >= 6) ? 32'd1 : 32'd0);
        end

        // Test 6: channel 2 pressed while channel 3 released on the same cycles.
        buttons_in = 4'b1000;
        ticks(10);
        buttons_in = 4'b0100;
        press_edge2 = -1;
        rel_edge3   = -2;
        for (int e = 0; e < 10; e++) begin
            tick();
            if (pressed[2])  press_edge2 = e;
            if (released[3]) rel_edge3   = e;
        end
        check_eq("t6_press2_edge", 32'(press_edge2), 32'd6);
        check_eq("t6_rel3_edge",   32'(rel_edge3),   32'd6);

        // Random phase.
        for (int c = 0; c < NB; c++) hold[c] = 0;
        for (int n = 0; n < 4000; n++) begin
            for (int c = 0; c < NB; c++) begin
                if (hold[c] == 0) begin
                    buttons_in[c] = 1'($urandom_range(0, 1));
                    hold[c] = $urandom_range(1, 10);
                end else begin
                    hold[c]--;
                end
                latch_clear[c] = ($urandom_range(0, 7) == 0);
            end
            reset = ($urandom_range(0, 299) == 0);
            tick();
        end
        reset = 1'b0;
        latch_clear = '0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/button_bank.md
Name: button_bank

Overview:
Multi-channel debouncer for board push-buttons. Generalises single-button, press-only, set-once handling to N channels.
- Synchronises each raw input.
- Filters bounce in both directions.
- Emits one-cycle press and release pulses.
- Keeps per-channel sticky flags that software/top-level logic can clear.
- Sits between the board pins and the CPU I/O register block.

Parameters:
NUM_BUTTONS, 8, number of independent channels (>=1).
COUNTER_SIZE, 8, width of each per-channel stability counter.
COUNTER_VALUE, 255, terminal count; must satisfy 1 <= COUNTER_VALUE <= 2^COUNTER_SIZE-1 (elaboration-time assertion).

Ports:
clk  input  1  system clock; single clock domain.
reset  input  1  synchronous, active-high reset.
buttons_in  input  NUM_BUTTONS  raw asynchronous button levels, 1 = pressed.
latch_clear  input  NUM_BUTTONS  per-channel clear strobe for latched.
buttons_state  output  NUM_BUTTONS  debounced level.
pressed  output  NUM_BUTTONS  one-cycle pulse on debounced 0->1.
released  output  NUM_BUTTONS  one-cycle pulse on debounced 1->0.
latched  output  NUM_BUTTONS  sticky flag, set by a press.
any_latched  output  1  OR-reduction of latched, registered.

Behaviour:
- All state updates on posedge clk. When reset=1, every register clears to 0 on the next edge, regardless of activity in progress:
  - sync stages, counters, buttons_state, pressed, released, latched, any_latched.
  - Any partially counted transition is discarded.
- Per channel i, all channels identical and independent.
- Synchroniser: two flops, s1 <= buttons_in[i], s2 <= s1. Only s2 is used downstream.
- mismatch = (s2 != buttons_state[i]).
- Counter:
  - if !mismatch: counter <= 0.
  - else if counter == COUNTER_VALUE: counter <= 0, buttons_state[i] <= s2.
  - else: counter <= counter + 1.
- Counter never exceeds COUNTER_VALUE, so no wrap-around.
- A single matching cycle anywhere in the run restarts the count (glitch rejection).
- A transition is accepted after COUNTER_VALUE+1 consecutive mismatching s2 samples.
- Latency: raw level stable from edge 0 (first edge that samples it) -> buttons_state changes at edge COUNTER_VALUE+2.
- pressed[i] / released[i]:
  - Registered, asserted in the same cycle buttons_state changes, high for exactly one cycle.
  - Never both high. No pulse while the level is unchanged.
- latched[i]:
  - Set on the edge where buttons_state rises, i.e. latched goes high together with the pressed pulse.
  - Cleared by latch_clear[i]=1.
  - Set has priority over a simultaneous clear.
  - Unaffected by release.
- any_latched is the registered OR of latched, one cycle behind latched.
- Behaviour on release is symmetric: same count and latency.
- Raw input held steady at the reset level produces no events after reset.

Decomposition:
- Package button_pkg holds:
  - default constants BUTTON_COUNTER_SIZE=8, BUTTON_COUNTER_VALUE=255, BUTTON_COUNT=8.
  - a function checking COUNTER_VALUE fits COUNTER_SIZE.
- Sub-module debounce_channel (parameters COUNTER_SIZE, COUNTER_VALUE):
  - Contains the synchroniser, counter, state, pulses and latch for one channel.
  - Ports clk, reset, button_in, latch_clear, state, pressed, released, latched.
- button_bank instantiates NUM_BUTTONS copies in a generate loop and computes any_latched.

Test Plan:
Run with COUNTER_VALUE=4, NUM_BUTTONS=4, COUNTER_SIZE=3.
1. After reset, buttons_in[0]=1 steady from edge 0 -> buttons_state[0], pressed[0], latched[0] go high after edge 6; pressed[0] low after edge 7; any_latched high after edge 7.
2. Bounce: buttons_in[1] toggles 1,0,1,0,1 one cycle each, then holds 1 -> no event during the bounce; state rises 6 edges after the final stable 1 is sampled.
3. Release: channel 0 held, then buttons_in[0]=0 -> released[0] pulses once after 6 edges; latched[0] stays 1; pressed never re-fires.
4. latch_clear[0]=1 for one cycle -> latched[0] drops next edge; latch_clear on the same edge as a new press -> latched stays 1.
5. Reset asserted for one cycle while channel 2 has a count of 3 -> all outputs 0 after reset; a transition then needs a full 6 edges from restart.
6. Independent channels: channel 2 pressed while channel 3 released simultaneously (both held from a prior debounced 1) -> pressed[2] and released[3] on the same cycle; no crosstalk on channels 0 and 1.
